// File: rtl/debounced_toggle_bank_pkg.sv
// Shared constants and helpers for the debounced toggle bank.
// Optional release counters are enabled by DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN.
package debounced_toggle_bank_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_FOLLOW = 1'b1
  } mode_e;

  // Wide enough to hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter, debounced level and
// registered release strobe.
module debounce_channel
  import debounced_toggle_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Stable,
  output logic o_Release,
  output logic o_Pulse
);

  localparam int unsigned CNT_BITS = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_stable;
  logic                r_stable_d;
  logic                r_pulse;
  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_next;
  logic                w_stable_next;
  logic                w_release;

  // Any sample equal to the accepted level restarts the stability window.
  always_comb begin
    w_cnt_next    = '0;
    w_stable_next = r_stable;
    if (r_sync2 != r_stable) begin
      if (r_cnt == CNT_LAST) begin
        w_stable_next = r_sync2;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  assign w_release = r_stable_d & ~r_stable;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_Switch;
      r_sync2    <= r_sync1;
      r_stable   <= w_stable_next;
      r_stable_d <= r_stable;
      r_pulse    <= w_release;
      r_cnt      <= w_cnt_next;
    end
  end

  assign o_Stable  = r_stable;
  assign o_Release = w_release;
  assign o_Pulse   = r_pulse;

endmodule

// File: rtl/debounced_toggle_bank.sv
// Multi-channel debounced switch bank with per-channel TOGGLE/FOLLOW LED drive.
// Define DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN to add per-channel release counters on o_Count.
module debounced_toggle_bank
  import debounced_toggle_bank_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_CH-1:0]       i_Switch,
  input  logic [NUM_CH-1:0]       i_Mode,
  output logic [NUM_CH-1:0]       o_Switch,
  output logic [NUM_CH-1:0]       o_Pulse,
  output logic [NUM_CH-1:0]       o_LED
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] o_Count
`endif
);

  logic [NUM_CH-1:0] w_stable;
  logic [NUM_CH-1:0] w_release;
  logic [NUM_CH-1:0] r_led;
  logic [NUM_CH-1:0] w_led_next;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (i_Switch[g]),
      .o_Stable (w_stable[g]),
      .o_Release(w_release[g]),
      .o_Pulse  (o_Pulse[g])
    );
  end

  // Mode is applied on the same edge it is seen, so a coincident release obeys the new mode.
  always_comb begin
    w_led_next = r_led;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode_e'(i_Mode[k]) == MODE_FOLLOW) begin
        w_led_next[k] = w_stable[k];
      end else begin
        w_led_next[k] = r_led[k] ^ w_release[k];
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_next;
    end
  end

  assign o_Switch = w_stable;
  assign o_LED    = r_led;

`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
  logic [NUM_CH*CNT_W-1:0] r_count;

  // Counts wrap naturally at 2^CNT_W.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_count <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (o_Pulse[k]) begin
          r_count[k*CNT_W +: CNT_W] <= r_count[k*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign o_Count = r_count;
`endif

endmodule

// File: tb/tb_debounced_toggle_bank.sv
// Scoreboard bench for debounced_toggle_bank (DEBOUNCE_CYCLES=4, NUM_CH=4, CNT_W=8).
// Count checks are active when DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN is defined.
module tb_debounced_toggle_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk   = 1'b0;
  logic              rst_l = 1'b1;
  logic [NUM_CH-1:0] sw    = '0;
  logic [NUM_CH-1:0] mode  = '0;
  logic [NUM_CH-1:0] o_sw;
  logic [NUM_CH-1:0] o_pulse;
  logic [NUM_CH-1:0] o_led;
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
  logic [NUM_CH*CNT_W-1:0] o_count;
`endif

  debounced_toggle_bank #(
    .NUM_CH         (NUM_CH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_l),
    .i_Switch(sw),
    .i_Mode  (mode),
    .o_Switch(o_sw),
    .o_Pulse (o_pulse),
    .o_LED   (o_led)
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
    ,
    .o_Count (o_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    string       tag;
    int          sel;   // 0 switch, 1 pulse, 2 led, 3 count
    int          ch;
    logic [3:0]  mask;
    logic [7:0]  val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:0] exp_sw  = '0;
  logic [3:0] exp_led = '0;
  logic [7:0] exp_cnt [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int unsigned due, input string tag, input int sel, input int ch,
                           input logic [3:0] mask, input logic [7:0] val);
    exp_t e;
    int   i;
    e.due  = due;
    e.tag  = tag;
    e.sel  = sel;
    e.ch   = ch;
    e.mask = mask;
    e.val  = val;
    i = 0;
    while (i < q.size() && q[i].due <= due) i++;
    q.insert(i, e);
  endtask

  exp_t m_e;
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].due <= cyc) begin
      m_e = q.pop_front();
      case (m_e.sel)
        0: check_eq({m_e.tag, ".sw"}, 32'(o_sw & m_e.mask), 32'(m_e.val[3:0] & m_e.mask));
        1: check_eq({m_e.tag, ".pulse"}, 32'(o_pulse & m_e.mask), 32'(m_e.val[3:0] & m_e.mask));
        2: check_eq({m_e.tag, ".led"}, 32'(o_led & m_e.mask), 32'(m_e.val[3:0] & m_e.mask));
        default: begin
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
          check_eq({m_e.tag, ".cnt"}, 32'(o_count[m_e.ch*CNT_W +: CNT_W]), 32'(m_e.val));
`endif
        end
      endcase
    end
  end

  // Change pins in mask to v at a falling edge; the next rising edge is edge e0.
  // flip_ch >= 0 flips that channel's mode just before the release/LED-update edge.
  task automatic drive_pins(input string tag, input logic [3:0] mask, input logic v,
                            input int flip_ch);
    int unsigned e0;
    logic [3:0]  mode_at;
    logic [3:0]  new_sw;
    logic [3:0]  led_after;
    sw      = v ? (sw | mask) : (sw & ~mask);
    e0      = cyc + 1;
    mode_at = mode;
    if (flip_ch >= 0) mode_at[flip_ch] = ~mode_at[flip_ch];
    new_sw    = v ? (exp_sw | mask) : (exp_sw & ~mask);
    led_after = exp_led;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) led_after[c] = mode_at[c] ? v : (v ? exp_led[c] : ~exp_led[c]);
    end
    expect_at(e0 + DEB, tag, 0, 0, mask, {4'h0, exp_sw});
    expect_at(e0 + DEB + 1, tag, 0, 0, mask, {4'h0, new_sw});
    expect_at(e0 + DEB + 1, tag, 2, 0, mask, {4'h0, exp_led});
    expect_at(e0 + DEB + 2, tag, 2, 0, mask, {4'h0, led_after});
    if (!v) begin
      expect_at(e0 + DEB + 1, tag, 1, 0, mask, 8'h00);
      expect_at(e0 + DEB + 2, tag, 1, 0, mask, {4'h0, mask});
      expect_at(e0 + DEB + 3, tag, 1, 0, mask, 8'h00);
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
      for (int c = 0; c < NUM_CH; c++) begin
        if (mask[c]) begin
          exp_cnt[c] = exp_cnt[c] + 8'd1;
          expect_at(e0 + DEB + 4, tag, 3, c, 4'h0, exp_cnt[c]);
        end
      end
`endif
    end else begin
      expect_at(e0 + DEB + 2, tag, 1, 0, mask, 8'h00);
    end
    exp_sw  = new_sw;
    exp_led = led_after;
    if (flip_ch >= 0) begin
      repeat (DEB + 2) @(negedge clk);
      mode[flip_ch] = ~mode[flip_ch];
      repeat (3) @(negedge clk);
    end else begin
      repeat (DEB + 5) @(negedge clk);
    end
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = '0;
    sw = 4'hF;
    #1 rst_l = 1'b0;
    @(negedge clk);

    // Reset held with all pins pressed.
    repeat (3) begin
      expect_at(cyc + 1, "rst_hold", 0, 0, 4'hF, 8'h00);
      expect_at(cyc + 1, "rst_hold", 1, 0, 4'hF, 8'h00);
      expect_at(cyc + 1, "rst_hold", 2, 0, 4'hF, 8'h00);
      @(negedge clk);
    end
    rst_l = 1'b1;
    drive_pins("rst_release", 4'hF, 1'b1, -1);

    // Simultaneous release of all channels.
    drive_pins("all_release", 4'hF, 1'b0, -1);

    // Clean toggles on ch0.
    drive_pins("ch0_press1", 4'h1, 1'b1, -1);
    drive_pins("ch0_rel1", 4'h1, 1'b0, -1);
    drive_pins("ch0_press2", 4'h1, 1'b1, -1);
    drive_pins("ch0_rel2", 4'h1, 1'b0, -1);

    // Bounce on ch1: never stable long enough.
    for (int i = 0; i < 20; i++) begin
      sw[1] = ~sw[1];
      repeat (2) begin
        expect_at(cyc + 1, "bounce", 0, 0, 4'h2, 8'h00);
        expect_at(cyc + 1, "bounce", 1, 0, 4'h2, 8'h00);
        @(negedge clk);
      end
    end
    drive_pins("bounce_hold", 4'h2, 1'b1, -1);
    drive_pins("bounce_rel", 4'h2, 1'b0, -1);

    // FOLLOW on ch2, then back to TOGGLE with LED lit.
    mode[2] = 1'b1;
    expect_at(cyc + 1, "follow_on", 2, 0, 4'h4, 8'h00);
    exp_led[2] = exp_sw[2];
    repeat (2) @(negedge clk);
    drive_pins("follow_press", 4'h4, 1'b1, -1);
    drive_pins("follow_rel", 4'h4, 1'b0, -1);
    drive_pins("follow_press2", 4'h4, 1'b1, -1);
    mode[2] = 1'b0;
    expect_at(cyc + 1, "follow_off", 2, 0, 4'h4, 8'h04);
    expect_at(cyc + 3, "follow_off", 2, 0, 4'h4, 8'h04);
    repeat (4) @(negedge clk);
    drive_pins("toggle_rel", 4'h4, 1'b0, -1);

    // ch3: get LED to 0 in TOGGLE, then switch to FOLLOW exactly on the release edge.
    drive_pins("ch3_press", 4'h8, 1'b1, -1);
    drive_pins("ch3_rel", 4'h8, 1'b0, -1);
    drive_pins("ch3_press2", 4'h8, 1'b1, -1);
    drive_pins("coincident", 4'h8, 1'b0, 3);
    mode[3] = 1'b0;
    expect_at(cyc + 1, "ch3_back", 2, 0, 4'h8, 8'h00);
    repeat (2) @(negedge clk);
    drive_pins("ch3_press3", 4'h8, 1'b1, -1);
    drive_pins("ch3_rel3", 4'h8, 1'b0, -1);
    drive_pins("ch3_press4", 4'h8, 1'b1, -1);

    // Reset in the middle of debouncing a ch3 release.
    sw[3] = 1'b0;
    repeat (4) @(negedge clk);
    rst_l = 1'b0;
    #1;
    check_eq("rst_mid.sw", 32'(o_sw), 32'h0);
    check_eq("rst_mid.led", 32'(o_led), 32'h0);
    check_eq("rst_mid.pulse", 32'(o_pulse), 32'h0);
`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
    check_eq("rst_mid.cnt", 32'(o_count), 32'h0);
    for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = '0;
`endif
    exp_sw  = '0;
    exp_led = '0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_at(cyc + 1, "post_rst", 0, 0, 4'hF, 8'h00);
      expect_at(cyc + 1, "post_rst", 1, 0, 4'hF, 8'h00);
      @(negedge clk);
    end

`ifdef DEBOUNCED_TOGGLE_BANK_EDGE_COUNT_EN
    // 257 releases on ch3 wraps its counter to 1.
    for (int i = 0; i < 257; i++) begin
      drive_pins("wrap_press", 4'h8, 1'b1, -1);
      drive_pins("wrap_rel", 4'h8, 1'b0, -1);
    end
`endif

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check_eq("drain", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
